// File: rtl/sd_spi_card_responder.sv
// sd_spi_card_responder
// SPI-mode SD card emulator. Oversamples the host SPI bus on clk, decodes
// 6-byte commands, answers with R1/R3/R7, and streams one 512-byte block
// per CMD17 from an external byte-fetch port.
//
// Ports:
//   clk, rst_n           system clock (>= 8x spi_clk), async active-low reset
//   spi_clk, cs, mosi    host SPI bus (mode 0), asynchronous to clk
//   miso                 card data out, 1 when idle
//   rd_start, rd_sector  CMD17 accepted pulse and its block address
//   rd_byte_req/idx      fetch request for block byte idx
//   rd_byte              fetched byte, stable 2 clks after rd_byte_req
//   card_ready           set once ACMD41 has answered 0x00
//
// Build option: define SD_RESP_CRC7_CHECK_EN to check the command CRC7.
module sd_spi_card_responder #(
    parameter int unsigned ACMD41_BUSY_COUNT = 2,
    parameter logic [31:0] OCR_VALUE         = 32'hC0FF8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_clk,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    output logic        rd_start,
    output logic [31:0] rd_sector,
    output logic        rd_byte_req,
    output logic [8:0]  rd_byte_idx,
    input  logic [7:0]  rd_byte,
    output logic        card_ready
);

    localparam logic [2:0] ST_HUNT     = 3'd0;
    localparam logic [2:0] ST_CMD_RX   = 3'd1;
    localparam logic [2:0] ST_NCR      = 3'd2;
    localparam logic [2:0] ST_RESP     = 3'd3;
    localparam logic [2:0] ST_DATA_GAP = 3'd4;
    localparam logic [2:0] ST_TOKEN    = 3'd5;
    localparam logic [2:0] ST_DATA     = 3'd6;
    localparam logic [2:0] ST_CRC      = 3'd7;

    logic [1:0]  r_sclk_s, r_cs_s, r_mosi_s;
    logic        r_sclk_d;
    logic [2:0]  r_bitcnt;
    logic [6:0]  r_rx;
    logic [7:0]  r_tx;
    logic        r_miso;
    logic [2:0]  r_state;
    logic [8:0]  r_cnt;
    logic [5:0]  r_cmd;
    logic [31:0] r_arg;
    logic [7:0]  r_r1;
    logic [31:0] r_resp;
    logic        r_ext;
    logic        r_data_cmd;
    logic        r_idle, r_app, r_ready;
    logic [7:0]  r_acnt;
    logic        r_rd_start, r_req;
    logic [31:0] r_sector;
    logic [8:0]  r_idx;
`ifdef SD_RESP_CRC7_CHECK_EN
    logic [6:0]  r_crc;
`endif

    logic        w_cs, w_rise, w_fall, w_done;
    logic [7:0]  w_byte;
    logic        w_crc_bad, w_ill, w_has_ext, w_rd_go;
    logic        w_idle_n, w_app_n, w_ready_n;
    logic [7:0]  w_acnt_n, w_r1;
    logic [31:0] w_ext;

    assign w_cs   = r_cs_s[1];
    assign w_rise = ~w_cs &  r_sclk_s[1] & ~r_sclk_d;
    assign w_fall = ~w_cs & ~r_sclk_s[1] &  r_sclk_d;
    assign w_byte = {r_rx, r_mosi_s[1]};
    assign w_done = w_rise & (r_bitcnt == 3'd7);

`ifdef SD_RESP_CRC7_CHECK_EN
    function automatic logic [6:0] f_crc7(input logic [6:0] crc, input logic [7:0] data);
        logic [6:0] c;
        logic [7:0] d;
        logic       fb;
        c = crc;
        d = data;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = c[6] ^ d[7];
            c  = {c[5:0], 1'b0};
            d  = {d[6:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction
    assign w_crc_bad = (w_byte[7:1] != r_crc);
`else
    assign w_crc_bad = 1'b0;
`endif

    // Command decode; only consumed on the last command byte.
    always_comb begin
        w_idle_n  = r_idle;
        w_app_n   = 1'b0;
        w_acnt_n  = r_acnt;
        w_ready_n = r_ready;
        w_ill     = 1'b0;
        w_has_ext = 1'b0;
        w_ext     = '0;
        w_rd_go   = 1'b0;
        if (!w_crc_bad) begin
            case (r_cmd)
                6'd0: begin
                    w_idle_n  = 1'b1;
                    w_ready_n = 1'b0;
                    w_acnt_n  = '0;
                end
                6'd8: begin
                    w_has_ext = 1'b1;
                    w_ext     = {16'h0000, 4'h0, r_arg[11:0]};
                end
                6'd55: w_app_n = 1'b1;
                6'd41: begin
                    if (!r_app) begin
                        w_ill = 1'b1;
                    end else if (32'(r_acnt) < ACMD41_BUSY_COUNT) begin
                        w_acnt_n = r_acnt + 8'd1;
                    end else begin
                        w_idle_n  = 1'b0;
                        w_ready_n = 1'b1;
                    end
                end
                6'd58: begin
                    w_has_ext = 1'b1;
                    w_ext     = OCR_VALUE;
                end
                6'd17: begin
                    if (r_idle) w_ill = 1'b1;
                    else        w_rd_go = 1'b1;
                end
                default: w_ill = 1'b1;
            endcase
        end
        w_r1 = {4'b0000, w_crc_bad, w_ill, 1'b0, w_idle_n};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_s   <= 2'b00;
            r_cs_s     <= 2'b11;
            r_mosi_s   <= 2'b11;
            r_sclk_d   <= 1'b0;
            r_bitcnt   <= '0;
            r_rx       <= '0;
            r_tx       <= '1;
            r_miso     <= 1'b1;
            r_state    <= ST_HUNT;
            r_cnt      <= '0;
            r_cmd      <= '0;
            r_arg      <= '0;
            r_r1       <= '1;
            r_resp     <= '0;
            r_ext      <= 1'b0;
            r_data_cmd <= 1'b0;
            r_idle     <= 1'b1;
            r_app      <= 1'b0;
            r_ready    <= 1'b0;
            r_acnt     <= '0;
            r_rd_start <= 1'b0;
            r_req      <= 1'b0;
            r_sector   <= '0;
            r_idx      <= '0;
`ifdef SD_RESP_CRC7_CHECK_EN
            r_crc      <= '0;
`endif
        end else begin
            r_sclk_s   <= {r_sclk_s[0], spi_clk};
            r_cs_s     <= {r_cs_s[0], cs};
            r_mosi_s   <= {r_mosi_s[0], mosi};
            r_sclk_d   <= r_sclk_s[1];
            r_rd_start <= 1'b0;
            r_req      <= 1'b0;
            if (w_cs) begin
                // Deselect aborts any transaction; card status is retained.
                r_bitcnt <= '0;
                r_state  <= ST_HUNT;
                r_tx     <= '1;
                r_miso   <= 1'b1;
            end else begin
                if (w_fall) begin
                    r_miso <= r_tx[7];
                    r_tx   <= {r_tx[6:0], 1'b1};
                end
                if (w_rise) begin
                    r_bitcnt <= r_bitcnt + 3'd1;
                    r_rx     <= {r_rx[5:0], r_mosi_s[1]};
                end
                if (w_done) begin
                    r_tx <= '1;
                    case (r_state)
                        ST_HUNT: begin
                            if (w_byte[7:6] == 2'b01) begin
                                r_cmd   <= w_byte[5:0];
                                r_cnt   <= '0;
                                r_state <= ST_CMD_RX;
`ifdef SD_RESP_CRC7_CHECK_EN
                                r_crc   <= f_crc7(7'h00, w_byte);
`endif
                            end
                        end
                        ST_CMD_RX: begin
                            if (r_cnt == 9'd4) begin
                                r_idle     <= w_idle_n;
                                r_app      <= w_app_n;
                                r_acnt     <= w_acnt_n;
                                r_ready    <= w_ready_n;
                                r_r1       <= w_r1;
                                r_resp     <= w_ext;
                                r_ext      <= w_has_ext;
                                r_data_cmd <= w_rd_go;
                                if (w_rd_go) begin
                                    r_sector   <= r_arg;
                                    r_rd_start <= 1'b1;
                                end
                                r_state <= ST_NCR;
                            end else begin
                                r_arg <= {r_arg[23:0], w_byte};
                                r_cnt <= r_cnt + 9'd1;
`ifdef SD_RESP_CRC7_CHECK_EN
                                r_crc <= f_crc7(r_crc, w_byte);
`endif
                            end
                        end
                        ST_NCR: begin
                            r_tx    <= r_r1;
                            r_cnt   <= r_ext ? 9'd4 : 9'd0;
                            r_state <= ST_RESP;
                        end
                        ST_RESP: begin
                            if (r_cnt != 9'd0) begin
                                r_tx   <= r_resp[31:24];
                                r_resp <= {r_resp[23:0], 8'h00};
                                r_cnt  <= r_cnt - 9'd1;
                            end else begin
                                r_state <= r_data_cmd ? ST_DATA_GAP : ST_HUNT;
                            end
                        end
                        ST_DATA_GAP: begin
                            r_tx    <= 8'hFE;
                            r_req   <= 1'b1;
                            r_idx   <= 9'd0;
                            r_state <= ST_TOKEN;
                        end
                        ST_TOKEN: begin
                            r_tx    <= rd_byte;
                            r_req   <= 1'b1;
                            r_idx   <= 9'd1;
                            r_cnt   <= '0;
                            r_state <= ST_DATA;
                        end
                        ST_DATA: begin
                            // r_cnt is the index of the byte now on the wire;
                            // fetch runs one byte ahead of the load.
                            if (r_cnt == 9'd511) begin
                                r_cnt   <= '0;
                                r_state <= ST_CRC;
                            end else begin
                                r_tx  <= rd_byte;
                                r_cnt <= r_cnt + 9'd1;
                                if (r_cnt != 9'd510) begin
                                    r_req <= 1'b1;
                                    r_idx <= r_cnt + 9'd2;
                                end
                            end
                        end
                        default: begin
                            if (r_cnt == 9'd0) r_cnt <= 9'd1;
                            else               r_state <= ST_HUNT;
                        end
                    endcase
                end
            end
        end
    end

    assign miso        = r_miso;
    assign rd_start    = r_rd_start;
    assign rd_sector   = r_sector;
    assign rd_byte_req = r_req;
    assign rd_byte_idx = r_idx;
    assign card_ready  = r_ready;

endmodule
